// File: rtl/hv_wdg_pkg.sv
// Shared watchdog definitions.
// - scan_state_e : register-scan FSM states.
// - CRC defaults : polynomial 8'h07, seed 8'h00 (no reflection, no final XOR).
// - crc_calc     : MSB-first CRC over the low dw bits of data, cw-bit result.
//                  This is also used by the register-file write-CRC path.
package hv_wdg_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, REQ, CHK} scan_state_e;

  localparam int unsigned CRC_MAX_W  = 32;
  localparam int unsigned DATA_MAX_W = 64;

  localparam logic [7:0] CRC_POLY_DEF = 8'h07;
  localparam logic [7:0] CRC_INIT_DEF = 8'h00;

  // The arguments are zero-extended to the maximum widths. The bit selects use
  // shifted masks, so dw and cw can come straight from module parameters.
  function automatic logic [CRC_MAX_W-1:0] crc_calc(
    input logic [DATA_MAX_W-1:0] data,
    input logic [CRC_MAX_W-1:0]  poly,
    input logic [CRC_MAX_W-1:0]  init,
    input int unsigned           dw = 8,
    input int unsigned           cw = 8
  );
    logic [CRC_MAX_W-1:0] crc;
    logic [CRC_MAX_W-1:0] mask;
    logic [CRC_MAX_W-1:0] top;
    logic                 fb;
    mask = '0;
    for (int unsigned k = 0; k < CRC_MAX_W; k++) begin
      if (k < cw) mask = mask | (CRC_MAX_W'(1) << k);
    end
    top = CRC_MAX_W'(1) << (cw - 1);
    crc = init & mask;
    for (int unsigned i = 0; i < DATA_MAX_W; i++) begin
      if (i < dw) begin
        fb  = (|(crc & top)) ^ (|(data & (DATA_MAX_W'(1) << (dw - 1 - i))));
        crc = ((crc << 1) ^ (fb ? poly : '0)) & mask;
      end
    end
    return crc;
  endfunction

endpackage

// File: rtl/hv_wdg_crc_chk.sv
// Combinational CRC recompute and compare.
// - data     : register data (REG_DW bits), the only input to the CRC
// - crc      : stored CRC returned with the read
// - mismatch : 1 when the recomputed CRC differs from the stored CRC
module hv_wdg_crc_chk
  import hv_wdg_pkg::*;
#(
  parameter int unsigned          REG_DW    = 8,
  parameter int unsigned          REG_CRC_W = 8,
  parameter logic [REG_CRC_W-1:0] CRC_POLY  = REG_CRC_W'(CRC_POLY_DEF),
  parameter logic [REG_CRC_W-1:0] CRC_INIT  = REG_CRC_W'(CRC_INIT_DEF)
) (
  input  logic [REG_DW-1:0]    data,
  input  logic [REG_CRC_W-1:0] crc,
  output logic                 mismatch
);

  logic [CRC_MAX_W-1:0] calc;

  always_comb begin
    calc = crc_calc(DATA_MAX_W'(data), CRC_MAX_W'(CRC_POLY), CRC_MAX_W'(CRC_INIT),
                    REG_DW, REG_CRC_W);
  end

  // The bits of calc above REG_CRC_W are zero, so a full-width compare is exact.
  assign mismatch = (calc != CRC_MAX_W'(crc));

endmodule

// File: rtl/hv_wdg_reg_scan.sv
// Watchdog register-scan engine: the read-only requester on the arbiter's wdg_scan port.
// It reads SCAN_START_ADDR..SCAN_END_ADDR in a loop, with SCAN_INTV_CYC idle cycles
// before each read. It checks each register's CRC and keeps sticky fault flags.
// Ports:
// - i_clk, i_rst_n          : clock and asynchronous active-low reset
// - i_scan_en               : scan enable (level)
// - i_err_clr               : clears the sticky flags and the error address (pulse)
// - o_wdg_scan_rac_rd_req   : read request, held until ack or timeout
// - o_wdg_scan_rac_addr     : read address (the scan pointer)
// - i_rac_wdg_scan_ack      : read ack (1-cycle pulse); data and crc are valid with it
// - o_scan_crc_err          : sticky CRC-mismatch flag
// - o_scan_timeout          : sticky ack-timeout flag
// - o_scan_err_addr         : address of the first fault since the last clear
// - o_scan_round_done       : 1-cycle pulse after SCAN_END_ADDR has been checked
module hv_wdg_reg_scan
  import hv_wdg_pkg::*;
#(
  parameter int unsigned          REG_AW          = 7,
  parameter int unsigned          REG_DW          = 8,
  parameter int unsigned          REG_CRC_W       = 8,
  parameter logic [REG_AW-1:0]    SCAN_START_ADDR = REG_AW'('h00),
  parameter logic [REG_AW-1:0]    SCAN_END_ADDR   = REG_AW'('h3F),
  parameter int unsigned          SCAN_INTV_CYC   = 64,
  parameter int unsigned          TIMEOUT_CYC     = 255,
  parameter logic [REG_CRC_W-1:0] CRC_POLY        = REG_CRC_W'(CRC_POLY_DEF),
  parameter logic [REG_CRC_W-1:0] CRC_INIT        = REG_CRC_W'(CRC_INIT_DEF)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scan_en,
  input  logic                 i_err_clr,
  output logic                 o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
  input  logic                 i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
  output logic                 o_scan_crc_err,
  output logic                 o_scan_timeout,
  output logic [REG_AW-1:0]    o_scan_err_addr,
  output logic                 o_scan_round_done
);

  localparam int unsigned INTV_W = $clog2(SCAN_INTV_CYC + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

  scan_state_e          state;
  scan_state_e          state_d;
  logic [REG_AW-1:0]    ptr;
  logic [INTV_W-1:0]    intv_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [REG_DW-1:0]    data_q;
  logic [REG_CRC_W-1:0] crc_q;
  logic                 crc_mismatch;
  logic                 ack_take;
  logic                 to_hit;
  logic                 advance;
  logic                 at_end;
  logic                 crc_fault;
  logic                 fault;
  logic                 capture;

  hv_wdg_crc_chk #(
    .REG_DW    (REG_DW),
    .REG_CRC_W (REG_CRC_W),
    .CRC_POLY  (CRC_POLY),
    .CRC_INIT  (CRC_INIT)
  ) u_crc_chk (
    .data     (data_q),
    .crc      (crc_q),
    .mismatch (crc_mismatch)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    ack_take  = 1'b0;
    to_hit    = 1'b0;
    advance   = 1'b0;
    crc_fault = 1'b0;
    at_end    = (ptr == SCAN_END_ADDR);
    case (state)
      IDLE: if (i_scan_en) state_d = WAIT;
      WAIT: begin
        if (!i_scan_en)                                      state_d = IDLE;
        else if (intv_cnt >= INTV_W'(SCAN_INTV_CYC - 1))     state_d = REQ;
      end
      REQ: begin
        // An ack on the last allowed cycle wins over the timeout.
        if (i_rac_wdg_scan_ack) begin
          ack_take = 1'b1;
          state_d  = CHK;
        end else if (to_cnt >= TO_W'(TIMEOUT_CYC - 1)) begin
          to_hit  = 1'b1;
          advance = 1'b1;
          state_d = i_scan_en ? WAIT : IDLE;
        end
      end
      CHK: begin
        advance   = 1'b1;
        crc_fault = crc_mismatch;
        state_d   = i_scan_en ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    fault   = crc_fault | to_hit;
    // A fault in the same cycle as a clear counts as the first fault after that clear.
    capture = fault & (i_err_clr | ~(o_scan_crc_err | o_scan_timeout));
  end

  assign o_wdg_scan_rac_rd_req = (state == REQ);
  assign o_wdg_scan_rac_addr   = ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr               <= SCAN_START_ADDR;
      intv_cnt          <= '0;
      to_cnt            <= '0;
      data_q            <= '0;
      crc_q             <= '0;
      o_scan_crc_err    <= 1'b0;
      o_scan_timeout    <= 1'b0;
      o_scan_err_addr   <= '0;
      o_scan_round_done <= 1'b0;
    end else begin
      if (state == WAIT && state_d == WAIT)
        intv_cnt <= (intv_cnt == INTV_W'(SCAN_INTV_CYC)) ? intv_cnt : intv_cnt + INTV_W'(1);
      else
        intv_cnt <= '0;

      if (state == REQ && state_d == REQ)
        to_cnt <= (to_cnt == TO_W'(TIMEOUT_CYC)) ? to_cnt : to_cnt + TO_W'(1);
      else
        to_cnt <= '0;

      if (ack_take) begin
        data_q <= i_rac_wdg_scan_data;
        crc_q  <= i_rac_wdg_scan_crc;
      end

      // Going to IDLE always rewinds the pointer, even straight after a check.
      if (state_d == IDLE)
        ptr <= SCAN_START_ADDR;
      else if (advance)
        ptr <= at_end ? SCAN_START_ADDR : ptr + REG_AW'(1);

      o_scan_round_done <= advance & at_end;
      o_scan_crc_err    <= crc_fault | (o_scan_crc_err & ~i_err_clr);
      o_scan_timeout    <= to_hit | (o_scan_timeout & ~i_err_clr);

      if (capture)        o_scan_err_addr <= ptr;
      else if (i_err_clr) o_scan_err_addr <= '0;
    end
  end

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// Self-checking bench for hv_wdg_reg_scan (window 0..5, interval 4, timeout 255).
// It runs a directed vector table first, then hand-written sequences for the enable drop
// and for asynchronous reset, then random accesses against a reference model.
module tb_hv_wdg_reg_scan;

  localparam logic [6:0]  START = 7'h00;
  localparam logic [6:0]  ENDA  = 7'h05;
  localparam int unsigned INTV  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_en;
  logic       err_clr;
  logic       rd_req;
  logic [6:0] addr;
  logic       ack;
  logic [7:0] ack_data;
  logic [7:0] ack_crc;
  logic       crc_err;
  logic       timeout;
  logic [6:0] err_addr;
  logic       round_done;

  hv_wdg_reg_scan #(
    .REG_AW          (7),
    .REG_DW          (8),
    .REG_CRC_W       (8),
    .SCAN_START_ADDR (START),
    .SCAN_END_ADDR   (ENDA),
    .SCAN_INTV_CYC   (INTV),
    .TIMEOUT_CYC     (255),
    .CRC_POLY        (8'h07),
    .CRC_INIT        (8'h00)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_scan_en             (scan_en),
    .i_err_clr             (err_clr),
    .o_wdg_scan_rac_rd_req (rd_req),
    .o_wdg_scan_rac_addr   (addr),
    .i_rac_wdg_scan_ack    (ack),
    .i_rac_wdg_scan_data   (ack_data),
    .i_rac_wdg_scan_crc    (ack_crc),
    .o_scan_crc_err        (crc_err),
    .o_scan_timeout        (timeout),
    .o_scan_err_addr       (err_addr),
    .o_scan_round_done     (round_done)
  );

  always #5 clk = ~clk;

  // delay: REQ cycle on which ack is given (1..255); 0 means the access gets no ack.
  typedef struct {
    int unsigned delay;
    logic [7:0]  data;
    logic [7:0]  crc;
    bit          clr;
    logic [6:0]  addr;
    bit          err;
    bit          to;
    logic [6:0]  eaddr;
    bit          done;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [6:0] m_ptr;
  bit         m_err;
  bit         m_to;
  logic [6:0] m_eaddr;

  task automatic chk(input string tag, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
  endtask

  // Reference CRC as the remainder of (data * x^8) divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
  endfunction

  // Result of one access in terms of faults and flags: fills in the expected fields.
  task automatic model_step(inout vec_t v);
    bit f_to;
    bit f_crc;
    f_to  = (v.delay == 0);
    f_crc = !f_to && (v.crc != ref_crc(v.data));
    v.addr = m_ptr;
    if ((f_crc || f_to) && (v.clr || (!m_err && !m_to))) m_eaddr = m_ptr;
    else if (v.clr)                                      m_eaddr = '0;
    m_err  = f_crc || (m_err && !v.clr);
    m_to   = f_to  || (m_to  && !v.clr);
    v.done = (m_ptr == ENDA);
    m_ptr  = v.done ? START : m_ptr + 7'd1;
    v.err   = m_err;
    v.to    = m_to;
    v.eaddr = m_eaddr;
  endtask

  task automatic wait_req(output int unsigned n);
    n = 0;
    while (!rd_req && n < 600) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Starts at a negedge before the request and ends at the negedge where the fault
  // outputs are updated (the first cycle after the check).
  task automatic do_access(input vec_t v, input int unsigned gap, input string tag);
    int unsigned n;
    bit          held;
    wait_req(n);
    chk(tag, "req_seen", 32'(rd_req), 32'd1);
    if (gap != 0) chk(tag, "wait_gap", n, gap);
    chk(tag, "req_addr", 32'(addr), 32'(v.addr));
    held = 1'b1;
    if (v.delay != 0) begin
      for (int unsigned c = 1; c < v.delay; c++) begin
        @(negedge clk);
        if (!rd_req || addr != v.addr) held = 1'b0;
      end
      ack = 1'b1; ack_data = v.data; ack_crc = v.crc;
      @(negedge clk);
      ack = 1'b0; err_clr = v.clr;
      chk(tag, "req_drop_ack", 32'(rd_req), 32'd0);
    end else begin
      for (int unsigned c = 1; c < 255; c++) begin
        @(negedge clk);
        if (!rd_req || addr != v.addr) held = 1'b0;
      end
      err_clr = v.clr;
    end
    chk(tag, "req_held", 32'(held), 32'd1);
    @(negedge clk);
    err_clr = 1'b0;
    if (v.delay == 0) chk(tag, "req_drop_to", 32'(rd_req), 32'd0);
    chk(tag, "crc_err",    32'(crc_err),    32'(v.err));
    chk(tag, "timeout",    32'(timeout),    32'(v.to));
    chk(tag, "err_addr",   32'(err_addr),   32'(v.eaddr));
    chk(tag, "round_done", 32'(round_done), 32'(v.done));
  endtask

  vec_t tbl [18];

  initial begin
    int unsigned n;
    bit          flag;
    vec_t        v;
    vec_t        tmp;

    //          delay data   crc    clr   addr  err   to    eaddr done
    tbl[0]  = '{3,   8'h00, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[1]  = '{3,   8'h01, 8'h07, 1'b0, 7'd1, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[2]  = '{3,   8'h00, 8'h00, 1'b0, 7'd2, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[3]  = '{1,   8'h80, 8'h89, 1'b0, 7'd3, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[4]  = '{5,   8'hFF, 8'hF3, 1'b0, 7'd4, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[5]  = '{2,   8'h10, 8'h70, 1'b0, 7'd5, 1'b0, 1'b0, 7'd0, 1'b1};
    tbl[6]  = '{3,   8'h01, 8'h07, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[7]  = '{3,   8'h01, 8'h06, 1'b0, 7'd1, 1'b1, 1'b0, 7'd1, 1'b0};
    tbl[8]  = '{255, 8'h00, 8'h00, 1'b0, 7'd2, 1'b1, 1'b0, 7'd1, 1'b0};
    tbl[9]  = '{2,   8'h10, 8'h00, 1'b0, 7'd3, 1'b1, 1'b0, 7'd1, 1'b0};
    tbl[10] = '{2,   8'h00, 8'h00, 1'b1, 7'd4, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[11] = '{0,   8'h00, 8'h00, 1'b0, 7'd5, 1'b0, 1'b1, 7'd5, 1'b1};
    tbl[12] = '{2,   8'h00, 8'h00, 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[13] = '{4,   8'hFF, 8'hF3, 1'b0, 7'd1, 1'b0, 1'b0, 7'd0, 1'b0};
    tbl[14] = '{0,   8'h00, 8'h00, 1'b0, 7'd2, 1'b0, 1'b1, 7'd2, 1'b0};
    tbl[15] = '{3,   8'hFF, 8'hF2, 1'b1, 7'd3, 1'b1, 1'b0, 7'd3, 1'b0};
    tbl[16] = '{1,   8'h80, 8'h89, 1'b0, 7'd4, 1'b1, 1'b0, 7'd3, 1'b0};
    tbl[17] = '{3,   8'h80, 8'h88, 1'b1, 7'd5, 1'b1, 1'b0, 7'd5, 1'b1};

    rst_n = 1'b0; scan_en = 1'b0; err_clr = 1'b0;
    ack = 1'b0; ack_data = '0; ack_crc = '0;
    m_ptr = START; m_err = 1'b0; m_to = 1'b0; m_eaddr = '0;

    repeat (2) @(negedge clk);
    chk("rst", "rd_req",     32'(rd_req),     32'd0);
    chk("rst", "addr",       32'(addr),       32'(START));
    chk("rst", "crc_err",    32'(crc_err),    32'd0);
    chk("rst", "timeout",    32'(timeout),    32'd0);
    chk("rst", "err_addr",   32'(err_addr),   32'd0);
    chk("rst", "round_done", 32'(round_done), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle", "rd_req", 32'(rd_req), 32'd0);

    // Directed table. The model is stepped too, so that later phases start in sync.
    scan_en = 1'b1;
    for (int unsigned i = 0; i < 18; i++) begin
      tmp = tbl[i];
      model_step(tmp);
      do_access(tbl[i], (i == 0) ? INTV + 1 : INTV, $sformatf("tbl%0d", i));
    end

    // Enable dropped during REQ: the access finishes, then the engine goes to IDLE and rewinds.
    wait_req(n);
    chk("endrop", "req_seen", 32'(rd_req), 32'd1);
    chk("endrop", "req_addr", 32'(addr), 32'(m_ptr));
    scan_en = 1'b0;
    flag = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (!rd_req) flag = 1'b0;
    end
    chk("endrop", "req_held", 32'(flag), 32'd1);
    ack = 1'b1; ack_data = 8'h01; ack_crc = 8'h07;
    @(negedge clk);
    ack = 1'b0;
    chk("endrop", "req_drop", 32'(rd_req), 32'd0);
    @(negedge clk);
    m_ptr = START;
    chk("endrop", "addr_rewind", 32'(addr), 32'(START));
    chk("endrop", "crc_err", 32'(crc_err), 32'(m_err));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = 1'b0; m_to = 1'b0; m_eaddr = '0;
    chk("endrop", "clr_err",   32'(crc_err),  32'd0);
    chk("endrop", "clr_eaddr", 32'(err_addr), 32'd0);
    // A stray ack carrying bad data while idle must be ignored.
    ack = 1'b1; ack_data = 8'h01; ack_crc = 8'h00;
    @(negedge clk);
    ack = 1'b0;
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rd_req) flag = 1'b1;
    end
    chk("idle2", "no_req",  32'(flag),    32'd0);
    chk("idle2", "crc_err", 32'(crc_err), 32'd0);
    scan_en = 1'b1;
    v = '{2, 8'h00, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 1'b0};
    model_step(v);
    do_access(v, INTV + 1, "reen");

    // Randomized accesses against the model.
    for (int unsigned i = 0; i < 30; i++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      v.delay = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 6);
      v.data  = 8'($urandom);
      v.crc   = ref_crc(v.data);
      if ($urandom_range(0, 2) == 0) v.crc = v.crc ^ (8'(1) << $urandom_range(0, 7));
      v.clr   = ($urandom_range(0, 5) == 0);
      model_step(v);
      do_access(v, INTV, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while a request is outstanding, with a fault flag set.
    v.delay = 2; v.data = 8'h5A; v.crc = ref_crc(8'h5A) ^ 8'h01; v.clr = 1'b0;
    model_step(v);
    do_access(v, INTV, "prerst");
    wait_req(n);
    chk("arst", "req_seen", 32'(rd_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst", "rd_req",     32'(rd_req),     32'd0);
    chk("arst", "addr",       32'(addr),       32'(START));
    chk("arst", "crc_err",    32'(crc_err),    32'd0);
    chk("arst", "timeout",    32'(timeout),    32'd0);
    chk("arst", "err_addr",   32'(err_addr),   32'd0);
    chk("arst", "round_done", 32'(round_done), 32'd0);
    @(negedge clk);
    scan_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
